dm_access_arbiter: RTL and testbench

Shares the single-port data memory (3072 words, word-addressed by A[13:2], combinational read, write at posedge Clk) between two requesters: the CPU load/store path and a DMA burst engine.
- Per-cycle grant, with CPU priority and bounded DMA starvation.
- Internal DMA burst sequencer generates beat addresses.
- Read data is registered on return.
- Out-of-range accesses are rejected.
- Sits between the MEM stage and the DM instance.

---
 rtl/dm_arb_pkg.sv | 22 ++
 rtl/dma_burst_seq.sv | 55 +++++
 rtl/dm_access_arbiter.sv | 158 +++++++++++++++
 tb/tb_dm_access_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory access arbiter.
// Holds the FSM state type, size defaults and the range check.
package dm_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        DMA_RUN = 1'b1
    } arb_state_t;

    localparam int DM_WORDS_DEF = 3072;
    localparam int MAX_LEN_DEF  = 16;

    function automatic logic in_range(
        input logic [31:0] a,
        input int unsigned words
    );
        logic [33:0] lim;
        lim = 34'(words) << 2;
        return {2'b00, a} < lim;
    endfunction

endpackage

// File: rtl/dma_burst_seq.sv
// DMA burst sequencer: latches a burst and walks its beat addresses.
// Reports the last beat and whether the current beat is out of range.
module dma_burst_seq
    import dm_arb_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF,
    parameter int MAX_LEN  = MAX_LEN_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        we_in,
    input  logic [31:0] base,
    input  logic [4:0]  len,
    input  logic        beat,
    output logic [31:0] addr,
    output logic        we,
    output logic        last,
    output logic        err
);

    logic [31:0] addr_q;
    logic [4:0]  cnt_q;
    logic        we_q;
    logic [4:0]  len_eff;

    // Oversized lengths are clipped to the longest legal burst
    always_comb begin
        len_eff = len;
        if (len > 5'(MAX_LEN))
            len_eff = 5'(MAX_LEN);
    end

    // Burst registers: load on start, advance one word per beat
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
        end else if (start) begin
            addr_q <= {base[31:2], 2'b00};
            cnt_q  <= len_eff;
            we_q   <= we_in;
        end else if (beat) begin
            addr_q <= addr_q + 32'd4;
            cnt_q  <= cnt_q - 5'd1;
        end
    end

    assign addr = addr_q;
    assign we   = we_q;
    assign last = (cnt_q == 5'd1);
    assign err  = !in_range(addr_q, DM_WORDS);

endmodule

// File: rtl/dm_access_arbiter.sv
// Arbitrates the data memory between the CPU MEM stage and a DMA engine.
// CPU has priority; a starved DMA beat is forced through after a limit.
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DM_WORDS     = DM_WORDS_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_LEN      = MAX_LEN_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CpuReq,
    input  logic        CpuWe,
    input  logic [31:0] CpuAddr,
    input  logic [31:0] CpuWD,
    input  logic [31:0] CpuPC,
    output logic        CpuGnt,
    output logic [31:0] CpuRData,
    output logic        CpuRValid,
    input  logic        DmaStart,
    input  logic        DmaWe,
    input  logic [31:0] DmaBase,
    input  logic [4:0]  DmaLen,
    input  logic [31:0] DmaWD,
    output logic        DmaBusy,
    output logic        DmaBeat,
    output logic [31:0] DmaRData,
    output logic        DmaRValid,
    output logic        DmaDone,
    output logic        DmaErr,
    output logic        AddrErr,
    output logic [31:0] MemA,
    output logic [31:0] MemWD,
    output logic        MemWr,
    output logic [31:0] MemPC,
    input  logic [31:0] MemRD
);

    arb_state_t  state_q, state_d;
    logic [2:0]  starve_q;
    logic        run, forced;
    logic        cpu_gnt, dma_gnt;
    logic        cpu_ok, dma_abort;
    logic        seq_start;
    logic [31:0] seq_addr;
    logic        seq_we, seq_last, seq_err;
    logic        done_q, err_q;

    assign run     = (state_q == DMA_RUN) && !Reset;
    assign forced  = run && (starve_q == 3'(STARVE_LIMIT));
    assign cpu_gnt = !Reset && CpuReq && !forced;
    assign dma_gnt = run && (!CpuReq || forced);
    assign cpu_ok  = in_range(CpuAddr, DM_WORDS);

    assign DmaBeat   = dma_gnt && !seq_err;
    assign dma_abort = dma_gnt && seq_err;
    assign seq_start = !Reset && (state_q == IDLE)
                     && DmaStart && (DmaLen != 5'd0);

    dma_burst_seq #(
        .DM_WORDS (DM_WORDS),
        .MAX_LEN  (MAX_LEN)
    ) u_seq (
        .Clk   (Clk),
        .Reset (Reset),
        .start (seq_start),
        .we_in (DmaWe),
        .base  (DmaBase),
        .len   (DmaLen),
        .beat  (DmaBeat),
        .addr  (seq_addr),
        .we    (seq_we),
        .last  (seq_last),
        .err   (seq_err)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state: enter on a real burst, leave on last beat or abort
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (seq_start)
                    state_d = DMA_RUN;
            end
            DMA_RUN: begin
                if (dma_abort || (DmaBeat && seq_last))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Starvation counter: counts beats lost to the CPU
    always_ff @(posedge Clk) begin
        if (Reset)
            starve_q <= '0;
        else if (!run || DmaBeat || state_d != DMA_RUN)
            starve_q <= '0;
        else if (cpu_gnt)
            starve_q <= starve_q + 3'd1;
    end

    // Memory-side mux driven by whichever side holds the grant
    always_comb begin
        MemA  = '0;
        MemWD = '0;
        MemWr = 1'b0;
        MemPC = '0;
        if (cpu_gnt) begin
            MemA  = CpuAddr;
            MemWD = CpuWD;
            MemWr = CpuWe && cpu_ok;
            MemPC = CpuPC;
        end else if (dma_gnt) begin
            MemA  = seq_addr;
            MemWD = DmaWD;
            MemWr = seq_we && !seq_err;
        end
    end

    // Return registers, completion and error pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            CpuRData  <= '0;
            CpuRValid <= 1'b0;
            DmaRData  <= '0;
            DmaRValid <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            AddrErr   <= 1'b0;
        end else begin
            CpuRValid <= cpu_gnt && !CpuWe;
            if (cpu_gnt && !CpuWe)
                CpuRData <= cpu_ok ? MemRD : 32'd0;
            DmaRValid <= DmaBeat && !seq_we;
            if (DmaBeat && !seq_we)
                DmaRData <= MemRD;
            done_q  <= (DmaBeat && seq_last) || dma_abort
                     || (!run && DmaStart && DmaLen == 5'd0);
            err_q   <= dma_abort;
            AddrErr <= cpu_gnt && !cpu_ok;
        end
    end

    assign CpuGnt  = cpu_gnt;
    assign DmaBusy = run;
    assign DmaDone = done_q;
    assign DmaErr  = err_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed testbench for dm_access_arbiter with a behavioural DM.
// Each scenario task drives inputs at negedge and checks inline.
module tb_dm_access_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CpuReq, CpuWe;
    logic [31:0] CpuAddr, CpuWD, CpuPC;
    logic        CpuGnt, CpuRValid;
    logic [31:0] CpuRData;
    logic        DmaStart, DmaWe;
    logic [31:0] DmaBase, DmaWD;
    logic [4:0]  DmaLen;
    logic        DmaBusy, DmaBeat, DmaRValid, DmaDone, DmaErr;
    logic [31:0] DmaRData;
    logic        AddrErr;
    logic [31:0] MemA, MemWD, MemPC, MemRD;
    logic        MemWr;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:3071];

    always #5 Clk = ~Clk;

    // Behavioural single-port DM: combinational read, posedge write
    assign MemRD = (MemA < 32'd12288) ? mem[MemA[13:2]] : 32'd0;
    always @(posedge Clk)
        if (MemWr && MemA < 32'd12288)
            mem[MemA[13:2]] <= MemWD;

    dm_access_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr),
        .CpuWD(CpuWD), .CpuPC(CpuPC), .CpuGnt(CpuGnt),
        .CpuRData(CpuRData), .CpuRValid(CpuRValid),
        .DmaStart(DmaStart), .DmaWe(DmaWe), .DmaBase(DmaBase),
        .DmaLen(DmaLen), .DmaWD(DmaWD), .DmaBusy(DmaBusy),
        .DmaBeat(DmaBeat), .DmaRData(DmaRData),
        .DmaRValid(DmaRValid), .DmaDone(DmaDone), .DmaErr(DmaErr),
        .AddrErr(AddrErr), .MemA(MemA), .MemWD(MemWD),
        .MemWr(MemWr), .MemPC(MemPC), .MemRD(MemRD)
    );

    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        CpuReq = 0; CpuWe = 0; CpuAddr = 0; CpuWD = 0; CpuPC = 0;
        DmaStart = 0; DmaWe = 0; DmaBase = 0; DmaLen = 0; DmaWD = 0;
        tick(); tick();
        Reset = 1'b0;
        #1;
        checks++;
        if ({CpuGnt, CpuRValid, DmaBusy, DmaBeat, DmaDone, DmaErr,
             AddrErr, MemWr, DmaRValid} !== 9'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0",
                {CpuGnt, CpuRValid, DmaBusy, DmaBeat, DmaDone,
                 DmaErr, AddrErr, MemWr, DmaRValid});
        end
        checks++;
        if (MemA !== 32'd0 || CpuRData !== 32'd0) begin
            failures++;
            $display("FAIL reset_data MemA=%h CpuRData=%h want 0",
                MemA, CpuRData);
        end
    endtask

    task automatic test_cpu_store_load;
        CpuReq = 1; CpuWe = 1; CpuAddr = 32'h10;
        CpuWD = 32'h1234_5678; CpuPC = 32'h400;
        #1;
        checks++;
        if (CpuGnt !== 1 || MemWr !== 1 || MemPC !== 32'h400) begin
            failures++;
            $display("FAIL cpu_store gnt=%b wr=%b pc=%h want 1 1 400",
                CpuGnt, MemWr, MemPC);
        end
        tick();
        CpuWe = 0; CpuPC = 32'h404;
        #1;
        checks++;
        if (CpuGnt !== 1 || MemWr !== 0 || CpuRValid !== 0) begin
            failures++;
            $display("FAIL cpu_load gnt=%b wr=%b rv=%b want 1 0 0",
                CpuGnt, MemWr, CpuRValid);
        end
        tick();
        CpuReq = 0;
        #1;
        checks++;
        if (CpuRValid !== 1 || CpuRData !== 32'h1234_5678) begin
            failures++;
            $display("FAIL cpu_rdata rv=%b data=%h want 1 12345678",
                CpuRValid, CpuRData);
        end
        tick();
        #1;
        checks++;
        if (CpuRValid !== 0 || CpuRData !== 32'h1234_5678) begin
            failures++;
            $display("FAIL cpu_rhold rv=%b data=%h want 0 12345678",
                CpuRValid, CpuRData);
        end
    endtask

    task automatic test_dma_write;
        DmaStart = 1; DmaWe = 1; DmaBase = 32'h100; DmaLen = 5'd4;
        tick();
        DmaStart = 0;
        for (int i = 0; i < 4; i++) begin
            DmaWD = 32'(i + 1);
            #1;
            checks++;
            if (DmaBeat !== 1 || MemWr !== 1 || DmaBusy !== 1
                || MemA !== 32'h100 + 32'(4 * i) || MemPC !== 0) begin
                failures++;
                $display("FAIL dma_wr_beat%0d beat=%b wr=%b A=%h want 1 1 %h",
                    i, DmaBeat, MemWr, MemA, 32'h100 + 32'(4 * i));
            end
            tick();
        end
        #1;
        checks++;
        if (DmaDone !== 1 || DmaErr !== 0 || DmaBusy !== 0) begin
            failures++;
            $display("FAIL dma_wr_done done=%b err=%b busy=%b want 1 0 0",
                DmaDone, DmaErr, DmaBusy);
        end
        checks++;
        if (mem[64] !== 1 || mem[65] !== 2
            || mem[66] !== 3 || mem[67] !== 4) begin
            failures++;
            $display("FAIL dma_wr_mem got=%h %h %h %h want 1 2 3 4",
                mem[64], mem[65], mem[66], mem[67]);
        end
        tick();
        #1;
        checks++;
        if (DmaDone !== 0) begin
            failures++;
            $display("FAIL dma_done_pulse got=%b want 0", DmaDone);
        end
    endtask

    task automatic test_starvation;
        logic exp_beat, exp_rv;
        int   nrv;
        nrv = 0;
        CpuReq = 1; CpuWe = 0; CpuAddr = 32'h10;
        DmaStart = 1; DmaWe = 0; DmaBase = 32'h100; DmaLen = 5'd3;
        tick();
        DmaStart = 0;
        for (int k = 0; k < 16; k++) begin
            exp_beat = (k % 5 == 4);
            exp_rv   = (k > 0) && ((k - 1) % 5 == 4);
            #1;
            checks++;
            if (DmaBeat !== exp_beat || CpuGnt !== !exp_beat) begin
                failures++;
                $display("FAIL starve_gnt k=%0d beat=%b gnt=%b want beat=%b",
                    k, DmaBeat, CpuGnt, exp_beat);
            end
            checks++;
            if (DmaRValid !== exp_rv
                || (exp_rv && DmaRData !== 32'((k - 1) / 5 + 1))) begin
                failures++;
                $display("FAIL starve_rd k=%0d rv=%b data=%h want rv=%b",
                    k, DmaRValid, DmaRData, exp_rv);
            end
            if (DmaRValid === 1)
                nrv++;
            if (k == 15) begin
                checks++;
                if (DmaDone !== 1 || DmaBusy !== 0) begin
                    failures++;
                    $display("FAIL starve_done done=%b busy=%b want 1 0",
                        DmaDone, DmaBusy);
                end
            end
            tick();
        end
        CpuReq = 0;
        checks++;
        if (nrv != 3) begin
            failures++;
            $display("FAIL starve_rvcount got=%0d want 3", nrv);
        end
    endtask

    task automatic test_range_abort;
        DmaStart = 1; DmaWe = 1; DmaBase = 32'h2FF8; DmaLen = 5'd4;
        tick();
        DmaStart = 0;
        for (int k = 0; k < 3; k++) begin
            DmaWD = 32'hA0 + 32'(k);
            #1;
            checks++;
            if (DmaBeat !== (k < 2) || MemWr !== (k < 2)
                || DmaBusy !== 1) begin
                failures++;
                $display("FAIL abort_beat%0d beat=%b wr=%b busy=%b A=%h",
                    k, DmaBeat, MemWr, DmaBusy, MemA);
            end
            tick();
        end
        #1;
        checks++;
        if (DmaDone !== 1 || DmaErr !== 1 || DmaBusy !== 0) begin
            failures++;
            $display("FAIL abort_done done=%b err=%b busy=%b want 1 1 0",
                DmaDone, DmaErr, DmaBusy);
        end
        checks++;
        if (mem[3070] !== 32'hA0 || mem[3071] !== 32'hA1) begin
            failures++;
            $display("FAIL abort_mem got=%h %h want a0 a1",
                mem[3070], mem[3071]);
        end
        tick();
        #1;
        checks++;
        if (DmaDone !== 0 || DmaErr !== 0) begin
            failures++;
            $display("FAIL abort_pulse done=%b err=%b want 0 0",
                DmaDone, DmaErr);
        end
    endtask

    task automatic test_cpu_range;
        CpuReq = 1; CpuWe = 1; CpuAddr = 32'h3000; CpuWD = 32'hDEAD;
        #1;
        checks++;
        if (CpuGnt !== 1 || MemWr !== 0 || AddrErr !== 0) begin
            failures++;
            $display("FAIL cpu_oor_st gnt=%b wr=%b aerr=%b want 1 0 0",
                CpuGnt, MemWr, AddrErr);
        end
        tick();
        CpuWe = 0;
        #1;
        checks++;
        if (AddrErr !== 1 || CpuGnt !== 1) begin
            failures++;
            $display("FAIL cpu_oor_err aerr=%b gnt=%b want 1 1",
                AddrErr, CpuGnt);
        end
        tick();
        CpuReq = 0;
        #1;
        checks++;
        if (AddrErr !== 1 || CpuRValid !== 1 || CpuRData !== 0) begin
            failures++;
            $display("FAIL cpu_oor_ld aerr=%b rv=%b data=%h want 1 1 0",
                AddrErr, CpuRValid, CpuRData);
        end
        tick();
        #1;
        checks++;
        if (AddrErr !== 0) begin
            failures++;
            $display("FAIL cpu_oor_clr aerr=%b want 0", AddrErr);
        end
    endtask

    task automatic test_len0;
        DmaStart = 1; DmaWe = 1; DmaBase = 32'h80; DmaLen = 5'd0;
        tick();
        DmaStart = 0;
        #1;
        checks++;
        if (DmaDone !== 1 || DmaBusy !== 0 || DmaErr !== 0
            || DmaBeat !== 0) begin
            failures++;
            $display("FAIL len0 done=%b busy=%b err=%b beat=%b want 1 0 0 0",
                DmaDone, DmaBusy, DmaErr, DmaBeat);
        end
        tick();
    endtask

    task automatic test_reset_midburst;
        DmaStart = 1; DmaWe = 1; DmaBase = 32'h200; DmaLen = 5'd8;
        tick();
        DmaStart = 0;
        DmaWD = 32'h11;
        tick();
        DmaWD = 32'h22;
        Reset = 1;
        #1;
        checks++;
        if (MemWr !== 0 || DmaBeat !== 0) begin
            failures++;
            $display("FAIL rst_mid wr=%b beat=%b want 0 0", MemWr, DmaBeat);
        end
        tick();
        Reset = 0;
        #1;
        checks++;
        if (DmaBusy !== 0 || DmaDone !== 0 || mem[129] !== 0
            || mem[128] !== 32'h11) begin
            failures++;
            $display("FAIL rst_after busy=%b done=%b m80=%h m81=%h",
                DmaBusy, DmaDone, mem[128], mem[129]);
        end
        DmaStart = 1; DmaWe = 1; DmaBase = 32'h300; DmaLen = 5'd1;
        tick();
        DmaStart = 0;
        DmaWD = 32'h55;
        #1;
        checks++;
        if (DmaBusy !== 1 || DmaBeat !== 1 || MemA !== 32'h300) begin
            failures++;
            $display("FAIL rst_restart busy=%b beat=%b A=%h want 1 1 300",
                DmaBusy, DmaBeat, MemA);
        end
        tick();
        #1;
        checks++;
        if (DmaDone !== 1 || mem[192] !== 32'h55) begin
            failures++;
            $display("FAIL rst_restart_done done=%b m=%h want 1 55",
                DmaDone, mem[192]);
        end
    endtask

    initial begin
        for (int i = 0; i < 3072; i++)
            mem[i] = 32'd0;
        Reset = 1;
        @(negedge Clk);
        test_reset();
        test_cpu_store_load();
        test_dma_write();
        test_starvation();
        test_range_abort();
        test_cpu_range();
        test_len0();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
